audio_mixer: RTL and testbench

Parametrised, time-multiplexed N-channel audio mixer. It accepts one frame of CH signed samples plus per-channel unsigned gains over a valid/ready handshake. Each channel is scaled and summed through a single shared multiply-accumulate, one channel per cycle. The result is rounded, range-limited to DATA_W and presented on a valid/ready output. It replaces the fixed two-input 16-bit adder in the audio effect path and sits between the effect stages and the output DAC/I2S serializer.

---
 rtl/audio_mixer_if.sv | 38 +++
 rtl/audio_mixer.sv | 160 ++++++++++++++++
 tb/tb_audio_mixer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mixer_if.sv
// Handshake bundle between a frame producer, the audio_mixer and the downstream sample consumer.
// master = producer/consumer side (testbench or neighbouring stages), slave = the mixer itself.
interface audio_mixer_if #(
    parameter int DATA_W = 16,
    parameter int CH     = 4,
    parameter int GAIN_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CH*DATA_W-1:0]     in_samples;
    logic [CH*GAIN_W-1:0]     in_gains;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_sample;
    logic                     clip;

    modport master (
        output in_valid,
        output in_samples,
        output in_gains,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sample,
        input  clip
    );

    modport slave (
        input  in_valid,
        input  in_samples,
        input  in_gains,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sample,
        output clip
    );
endinterface

// File: rtl/audio_mixer.sv
// Time-multiplexed CH-channel mixer: one shared MAC per cycle, round, range-limit, valid/ready out.
// Optional build macro MIXER_SATURATE_EN: saturate to DATA_W and flag clip; otherwise wrap, clip = 0.
module audio_mixer #(
    parameter int DATA_W    = 16,
    parameter int CH        = 4,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    audio_mixer_if.slave  mix
);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(CH);
    localparam int IDX_W  = $clog2(CH);

    localparam logic signed [ACC_W-1:0] RND_C =
        {{(ACC_W-1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  samp_q [CH];
    logic signed [DATA_W-1:0]  samp_d [CH];
    logic [GAIN_W-1:0]         gain_q [CH];
    logic [GAIN_W-1:0]         gain_d [CH];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_W-1:0]         out_sample_q, out_sample_d;
    logic                      clip_q, clip_d;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   rnd_s;

`ifdef MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX_C =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN_C =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sat_s;

    // Returns {clip, limited sample}; the MSB flags that the value was pinned to a rail.
    function automatic logic [DATA_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic [DATA_W:0] res;
        if (v > SAT_MAX_C) begin
            res = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < SAT_MIN_C) begin
            res = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = {1'b0, DATA_W'(v)};
        end
        return res;
    endfunction
`endif

    assign mix.in_ready   = (state_q == IDLE);
    assign mix.out_valid  = out_valid_q;
    assign mix.out_sample = out_sample_q;
    assign mix.clip       = clip_q;

    // Next-state and datapath: capture frame, accumulate one channel per cycle, round/limit, hold output.
    always_comb begin
        state_d      = state_q;
        samp_d       = samp_q;
        gain_d       = gain_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        out_valid_d  = out_valid_q;
        out_sample_d = out_sample_q;
        clip_d       = clip_q;
        // Gain is zero-extended into a signed operand so the multiply stays two's complement.
        prod_s = PROD_W'(samp_q[idx_q]) * PROD_W'($signed({1'b0, gain_q[idx_q]}));
        rnd_s  = (acc_q + RND_C) >>> GAIN_FRAC;
`ifdef MIXER_SATURATE_EN
        sat_s  = sat_fn(rnd_s);
`endif

        case (state_q)
            IDLE: begin
                if (mix.in_valid) begin
                    for (int k = 0; k < CH; k++) begin
                        samp_d[k] = mix.in_samples[k*DATA_W +: DATA_W];
                        gain_d[k] = mix.in_gains[k*GAIN_W +: GAIN_W];
                    end
                    acc_d   = {ACC_W{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(prod_s);
                if (idx_q == IDX_W'(CH - 1)) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = SCALE;
                end else begin
                    idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_d = ACCUM;
                end
            end
            SCALE: begin
`ifdef MIXER_SATURATE_EN
                out_sample_d = sat_s[DATA_W-1:0];
                clip_d       = sat_s[DATA_W];
`else
                out_sample_d = DATA_W'(rnd_s);
                clip_d       = 1'b0;
`endif
                out_valid_d  = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (mix.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = OUT;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partially accumulated frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            acc_q        <= {ACC_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_sample_q <= {DATA_W{1'b0}};
            clip_q       <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                samp_q[k] <= {DATA_W{1'b0}};
                gain_q[k] <= {GAIN_W{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            clip_q       <= clip_d;
            for (int k = 0; k < CH; k++) begin
                samp_q[k] <= samp_d[k];
                gain_q[k] <= gain_d[k];
            end
        end
    end
endmodule

// File: tb/tb_audio_mixer.sv
// Self-checking bench for audio_mixer: directed cases plus randomized frames against a sum-of-products model.
module tb_audio_mixer;
    localparam int DATA_W    = 16;
    localparam int CH        = 4;
    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 6;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    audio_mixer_if #(.DATA_W(DATA_W), .CH(CH), .GAIN_W(GAIN_W)) mif ();

    audio_mixer #(
        .DATA_W(DATA_W), .CH(CH), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .mix    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, floor((sum + half) / 2^frac), then saturate or wrap.
    function automatic void model(input logic [CH*DATA_W-1:0] s, input logic [CH*GAIN_W-1:0] g,
                                  output longint exp_s, output longint exp_c);
        longint acc;
        longint r;
        longint hi;
        longint lo;
        logic [DATA_W-1:0] w;
        acc = 0;
        for (int k = 0; k < CH; k++)
            acc += longint'($signed(s[k*DATA_W +: DATA_W])) * longint'(g[k*GAIN_W +: GAIN_W]);
        r  = (acc + (longint'(1) << (GAIN_FRAC - 1))) >>> GAIN_FRAC;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -(longint'(1) << (DATA_W - 1));
`ifdef MIXER_SATURATE_EN
        if (r > hi) begin exp_s = hi; exp_c = 1; end
        else if (r < lo) begin exp_s = lo; exp_c = 1; end
        else begin exp_s = r; exp_c = 0; end
`else
        w     = r[DATA_W-1:0];
        exp_s = longint'($signed(w));
        exp_c = 0;
`endif
    endfunction

    function automatic logic [CH*DATA_W-1:0] ps(input int a, input int b, input int c, input int d);
        return {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    endfunction

    function automatic logic [CH*GAIN_W-1:0] pg(input int a, input int b, input int c, input int d);
        return {GAIN_W'(d), GAIN_W'(c), GAIN_W'(b), GAIN_W'(a)};
    endfunction

    // Offer one frame, check latency/result/hold behaviour, then complete the output handshake.
    task automatic run_frame(input string tag, input logic [CH*DATA_W-1:0] s,
                             input logic [CH*GAIN_W-1:0] g, input int hold, input bit offer,
                             input logic [CH*DATA_W-1:0] ns, input logic [CH*GAIN_W-1:0] ng,
                             output longint got_s, output longint got_c);
        longint es;
        longint ec;
        int     cnt;
        model(s, g, es, ec);
        mif.in_samples = s;
        mif.in_gains   = g;
        mif.in_valid   = 1'b1;
        cnt = 0;
        while (!mif.in_ready && cnt < 64) begin
            @(posedge clk); #1; cnt++;
        end
        check({tag, ":ready_before_accept"}, longint'(mif.in_ready), 1);
        @(posedge clk); #1;
        mif.in_valid = 1'b0;
        for (int k = 0; k < CH; k++) mif.in_samples[k*DATA_W +: DATA_W] = DATA_W'($urandom());
        mif.in_gains = {CH{GAIN_W'($urandom())}};
        check({tag, ":ready_low_busy"}, longint'(mif.in_ready), 0);
        cnt = 0;
        while (!mif.out_valid && cnt < 64) begin
            @(posedge clk); #1; cnt++;
        end
        check({tag, ":latency"}, cnt, CH + 1);
        got_s = longint'($signed(mif.out_sample));
        got_c = longint'(mif.clip);
        check({tag, ":sample"}, got_s, es);
        check({tag, ":clip"}, got_c, ec);
        if (offer) begin
            mif.in_valid   = 1'b1;
            mif.in_samples = ns;
            mif.in_gains   = ng;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, longint'(mif.out_valid), 1);
            check({tag, ":hold_sample"}, longint'($signed(mif.out_sample)), es);
            check({tag, ":hold_clip"}, longint'(mif.clip), ec);
            check({tag, ":hold_ready"}, longint'(mif.in_ready), 0);
        end
        mif.out_ready = 1'b1;
        @(posedge clk); #1;
        mif.out_ready = 1'b0;
        check({tag, ":valid_drop"}, longint'(mif.out_valid), 0);
        check({tag, ":ready_back"}, longint'(mif.in_ready), 1);
        check({tag, ":clip_kept"}, longint'(mif.clip), ec);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        longint gs;
        longint gc;
        logic [CH*DATA_W-1:0] s;
        logic [CH*GAIN_W-1:0] g;
        n_cmp = 0;
        n_err = 0;
        reset_n        = 1'b0;
        mif.in_valid   = 1'b0;
        mif.in_samples = '0;
        mif.in_gains   = '0;
        mif.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(mif.out_valid), 0);
        check("rst_out_sample", longint'(mif.out_sample), 0);
        check("rst_clip", longint'(mif.clip), 0);
        check("rst_in_ready", longint'(mif.in_ready), 1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_frame("basic", ps(1000, 2000, -500, 0), pg(64, 64, 64, 64), 0, 1'b0, '0, '0, gs, gc);
        check("basic_const", gs, 2500);
        check("basic_clip_const", gc, 0);

        run_frame("rnd_up", ps(3, 0, 0, 0), pg(32, 0, 0, 0), 1, 1'b0, '0, '0, gs, gc);
        check("rnd_up_const", gs, 2);
        run_frame("rnd_neg", ps(-3, 0, 0, 0), pg(32, 0, 0, 0), 0, 1'b0, '0, '0, gs, gc);
        check("rnd_neg_const", gs, -1);
        run_frame("mute", ps(12345, 0, 0, 0), pg(0, 0, 0, 0), 0, 1'b0, '0, '0, gs, gc);
        check("mute_const", gs, 0);

        run_frame("neg_rail", ps(-32768, -32768, -32768, -32768), pg(64, 64, 64, 64), 0, 1'b0, '0, '0, gs, gc);
`ifdef MIXER_SATURATE_EN
        check("neg_rail_const", gs, -32768);
        check("neg_rail_clip_const", gc, 1);
`else
        check("neg_rail_const", gs, 0);
        check("neg_rail_clip_const", gc, 0);
`endif

        run_frame("pos_rail", ps(30000, 30000, 30000, 30000), pg(64, 64, 64, 64), 2, 1'b0, '0, '0, gs, gc);
`ifdef MIXER_SATURATE_EN
        check("pos_rail_const", gs, 32767);
        check("pos_rail_clip_const", gc, 1);
`else
        check("pos_rail_const", gs, -11072);
        check("pos_rail_clip_const", gc, 0);
`endif

        // Abort a frame mid-accumulation; the stale output from the previous frame must clear.
        mif.in_samples = ps(9000, 9000, 9000, 9000);
        mif.in_gains   = pg(255, 255, 255, 255);
        mif.in_valid   = 1'b1;
        @(posedge clk); #1;
        mif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", longint'(mif.out_valid), 0);
        check("abort_out_sample", longint'(mif.out_sample), 0);
        check("abort_clip", longint'(mif.clip), 0);
        check("abort_in_ready", longint'(mif.in_ready), 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_frame("after_abort", ps(100, -200, 300, 50), pg(64, 128, 32, 255), 0, 1'b0, '0, '0, gs, gc);
        check("after_abort_const", gs, 100 - 400 + 150 + 199);

        // Backpressure with a second frame waiting; it must be taken right after the handshake.
        run_frame("bp_a", ps(1000, 2000, -500, 0), pg(64, 64, 64, 64), 10, 1'b1,
                  ps(100, 200, 300, 400), pg(64, 64, 64, 64), gs, gc);
        check("bp_a_const", gs, 2500);
        run_frame("bp_b", ps(100, 200, 300, 400), pg(64, 64, 64, 64), 0, 1'b0, '0, '0, gs, gc);
        check("bp_b_const", gs, 1000);

        for (int n = 0; n < 120; n++) begin
            for (int k = 0; k < CH; k++) begin
                case ($urandom_range(0, 3))
                    0:       s[k*DATA_W +: DATA_W] = 16'h7FFF;
                    1:       s[k*DATA_W +: DATA_W] = 16'h8000;
                    default: s[k*DATA_W +: DATA_W] = DATA_W'($urandom());
                endcase
                case ($urandom_range(0, 4))
                    0:       g[k*GAIN_W +: GAIN_W] = 8'd0;
                    1:       g[k*GAIN_W +: GAIN_W] = 8'd255;
                    default: g[k*GAIN_W +: GAIN_W] = GAIN_W'($urandom());
                endcase
            end
            run_frame("rand", s, g, $urandom_range(0, 3), 1'b0, '0, '0, gs, gc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
